// File: rtl/matmul_drain_pkg.sv
// Shared types and constants for the C-matrix result drain.
package matmul_drain_pkg;

  localparam int DWIDTH            = 8;
  localparam int MAT_MUL_SIZE      = 8;
  localparam int AWIDTH            = 11;
  localparam int ADDR_STRIDE_WIDTH = 8;
  localparam int ROW_IDX_W         = 3;
  localparam int FIFO_DEPTH        = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

  // Index of the highest set bit of a row mask; the row that carries m_last.
  function automatic logic [ROW_IDX_W-1:0] highest_row(input logic [MAT_MUL_SIZE-1:0] mask);
    highest_row = '0;
    for (int r = 0; r < MAT_MUL_SIZE; r++) begin
      if (mask[r]) highest_row = ROW_IDX_W'(r);
    end
  endfunction

endpackage

// File: rtl/matmul_result_drain_fifo.sv
// Two-entry FIFO with registered head outputs and an occupancy count.
module drain_fifo2
  import matmul_drain_pkg::*;
#(
  parameter int EW = 68
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [EW-1:0] push_data,
  input  logic          pop,
  output logic [EW-1:0] head_data,
  output logic          head_valid,
  output logic [1:0]    count
);

  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic          pop_ok;

  assign pop_ok     = pop && (count_q != 2'd0);
  assign head_data  = head_q;
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

  // Next entry contents and occupancy for every push/pop combination.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data;
        else                 tail_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'(FIFO_DEPTH)) begin
          head_d = tail_q;
          tail_d = push_data;
        end else begin
          head_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Entry and count registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: the entries are reset because the head entry drives m_data, which must read 0 out of reset.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/matmul_result_drain.sv
// Reads result matrix C row by row from the C BRAM and streams the masked-in
// rows on a valid/ready interface, with credit-based flow control into a
// two-entry output FIFO.
module matmul_result_drain
  import matmul_drain_pkg::*;
#(
  parameter int DWIDTH            = matmul_drain_pkg::DWIDTH,
  parameter int MAT_MUL_SIZE      = matmul_drain_pkg::MAT_MUL_SIZE,
  parameter int AWIDTH            = matmul_drain_pkg::AWIDTH,
  parameter int ADDR_STRIDE_WIDTH = matmul_drain_pkg::ADDR_STRIDE_WIDTH
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [ADDR_STRIDE_WIDTH-1:0]   addr_stride,
  input  logic [MAT_MUL_SIZE-1:0]        row_mask,
  input  logic                           clear_done,
  output logic                           busy,
  output logic                           done,
  output logic [AWIDTH-1:0]              bram_addr_c_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_c_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_c_ext,
  output logic [MAT_MUL_SIZE-1:0]        bram_we_c_ext,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] m_data,
  output logic [2:0]                     m_row_idx,
  output logic                           m_last
);

  localparam int EW = MAT_MUL_SIZE*DWIDTH + 4;
  localparam logic [2:0] LAST_ROW = 3'(MAT_MUL_SIZE-1);

  drain_state_e state_q, state_d;

  logic [MAT_MUL_SIZE-1:0]      mask_q, mask_d;
  logic [ADDR_STRIDE_WIDTH-1:0] stride_q, stride_d;
  logic [AWIDTH-1:0]            addr_q, addr_d;
  logic [AWIDTH-1:0]            last_addr_q, last_addr_d;
  logic [2:0]                   row_q, row_d;
  logic [2:0]                   last_row_q, last_row_d;
  logic                         inflight_q, inflight_d;
  logic [2:0]                   infl_row_q, infl_row_d;
  logic                         infl_last_q, infl_last_d;

  logic [1:0]    fifo_count;
  logic          pop;
  logic          row_sel;
  logic          credit_ok;
  logic          rd_issue;
  logic          row_adv;
  logic [EW-1:0] head_data;

  assign pop     = m_valid && m_ready;
  assign row_sel = mask_q[row_q];
  // fifo_count + inflight - pop < 2, rearranged so nothing underflows.
  assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign rd_issue  = (state_q == ST_RUN) && row_sel && credit_ok;
  assign row_adv   = (state_q == ST_RUN) && (!row_sel || credit_ok);

  // The read port sees the current row address only while a read is issued.
  assign bram_addr_c_ext  = rd_issue ? addr_q : last_addr_q;
  assign bram_wdata_c_ext = '0;
  assign bram_we_c_ext    = '0;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (row_mask != '0) ? ST_RUN : ST_DONE;
      ST_RUN:   if (row_adv && (row_q == LAST_ROW)) state_d = ST_FLUSH;
      ST_FLUSH: if ((fifo_count == 2'd0) && !inflight_q) state_d = ST_DONE;
      ST_DONE:  if (clear_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    done = (state_q == ST_DONE);
  end

  // Row walk: latch the job on start, advance the accumulating address per row.
  always_comb begin
    mask_d      = mask_q;
    stride_d    = stride_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    row_d       = row_q;
    last_row_d  = last_row_q;
    if ((state_q == ST_IDLE) && start) begin
      mask_d     = row_mask;
      stride_d   = addr_stride;
      addr_d     = base_addr;
      row_d      = '0;
      last_row_d = highest_row(row_mask);
    end
    if (row_adv) begin
      addr_d = addr_q + AWIDTH'(stride_q);
      row_d  = row_q + 3'd1;
    end
    if (rd_issue) last_addr_d = addr_q;
    inflight_d  = rd_issue;
    infl_row_d  = row_q;
    infl_last_d = (row_q == last_row_q);
  end

  // Job and read-tracking registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mask_q      <= '0;
      stride_q    <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      row_q       <= '0;
      last_row_q  <= '0;
      inflight_q  <= 1'b0;
      infl_row_q  <= '0;
      infl_last_q <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      stride_q    <= stride_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      row_q       <= row_d;
      last_row_q  <= last_row_d;
      inflight_q  <= inflight_d;
      infl_row_q  <= infl_row_d;
      infl_last_q <= infl_last_d;
    end
  end

  drain_fifo2 #(.EW(EW)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (inflight_q),
    .push_data  ({bram_rdata_c_ext, infl_row_q, infl_last_q}),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (m_valid),
    .count      (fifo_count)
  );

  assign m_data    = head_data[EW-1:4];
  assign m_row_idx = head_data[3:1];
  assign m_last    = head_data[0];

endmodule

// File: tb/tb_matmul_result_drain.sv
// Self-checking bench for matmul_result_drain: BRAM model, beat monitor and
// a row-list reference model of the drain.
module tb_matmul_result_drain;

  typedef struct packed {
    logic [2:0]  idx;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        clear_done = 1'b0;
  logic        m_ready = 1'b0;
  logic [10:0] base_addr = '0;
  logic [7:0]  addr_stride = '0;
  logic [7:0]  row_mask = '0;
  logic        busy, done, m_valid, m_last;
  logic [10:0] bram_addr_c_ext;
  logic [63:0] bram_rdata_c_ext = '0;
  logic [63:0] bram_wdata_c_ext, m_data;
  logic [7:0]  bram_we_c_ext;
  logic [2:0]  m_row_idx;

  logic [63:0] mem [0:2047];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  beat_t got_q[$];
  int    got_cyc[$];
  int    addr_log[$];
  bit    saw_valid;
  int    first_valid;

  matmul_result_drain dut (
    .clk              (clk),
    .resetn           (resetn),
    .start            (start),
    .base_addr        (base_addr),
    .addr_stride      (addr_stride),
    .row_mask         (row_mask),
    .clear_done       (clear_done),
    .busy             (busy),
    .done             (done),
    .bram_addr_c_ext  (bram_addr_c_ext),
    .bram_rdata_c_ext (bram_rdata_c_ext),
    .bram_wdata_c_ext (bram_wdata_c_ext),
    .bram_we_c_ext    (bram_we_c_ext),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_row_idx        (m_row_idx),
    .m_last           (m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // C BRAM port 1: registered read, one cycle latency.
  always @(posedge clk) bram_rdata_c_ext <= mem[bram_addr_c_ext];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: collects handshakes, checks hold-while-stalled, FIFO occupancy and read addresses.
  beat_t prev_beat;
  bit    stall_prev = 1'b0;
  logic [10:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!resetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_hold", beat_t'{m_row_idx, m_data, m_last}, prev_beat);
      end
      if (busy) check("fifo_occ_le2", dut.fifo_count <= 2'd2, 1'b1);
      if (m_valid) begin
        saw_valid = 1'b1;
        if (first_valid < 0) first_valid = cyc;
      end
      if (m_valid && m_ready) begin
        got_q.push_back(beat_t'{m_row_idx, m_data, m_last});
        got_cyc.push_back(cyc);
      end
      if (busy && (bram_addr_c_ext != prev_addr)) addr_log.push_back(int'(bram_addr_c_ext));
      stall_prev = m_valid && !m_ready;
      prev_beat  = beat_t'{m_row_idx, m_data, m_last};
    end
    prev_addr = bram_addr_c_ext;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_valid"}, m_valid, 1'b0);
    check({tag, "_last"}, m_last, 1'b0);
    check({tag, "_idx"}, m_row_idx, 3'd0);
    check({tag, "_data"}, m_data, 64'd0);
    check({tag, "_addr"}, bram_addr_c_ext, 11'd0);
  endtask

  // One drain job compared against the reference row list.
  task automatic run_case(input string tag, input logic [10:0] b, input logic [7:0] s,
                          input logic [7:0] m, input int pct, input bit poke,
                          input bit chk_addr, input bit timing);
    beat_t exp_q[$];
    int    exp_addr[$];
    int    hi;
    int    a;
    int    n;
    int    s_edge;
    hi = -1;
    for (int r = 0; r < 8; r++) if (m[r]) hi = r;
    for (int r = 0; r < 8; r++) begin
      if (m[r]) begin
        a = (int'(b) + r * int'(s)) % 2048;
        exp_q.push_back(beat_t'{3'(r), mem[a], (r == hi)});
        exp_addr.push_back(a);
      end
    end
    got_q.delete();
    got_cyc.delete();
    addr_log.delete();
    first_valid = -1;
    base_addr   = b;
    addr_stride = s;
    row_mask    = m;
    start       = 1'b1;
    m_ready     = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
    tick();
    s_edge = cyc;
    start = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      m_ready    = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      start      = poke && (n == 4);
      clear_done = poke && (n == 4);
      tick();
      if (poke && n == 4) begin
        check({tag, "_poke_busy"}, busy, 1'b1);
        check({tag, "_poke_done"}, done, 1'b0);
      end
      n++;
    end
    start      = 1'b0;
    clear_done = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_nbeats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    if (chk_addr) begin
      check({tag, "_nreads"}, addr_log.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++)
        check($sformatf("%s_addr%0d", tag, i), addr_log[i], exp_addr[i]);
    end
    if (timing && got_cyc.size() == 8) begin
      check({tag, "_first_valid"}, first_valid, s_edge + 2);
      for (int i = 0; i < 8; i++)
        check($sformatf("%s_beat%0d_cyc", tag, i), got_cyc[i], s_edge + 2 + i);
      // Last handshake lands on edge got_cyc[7]+1; done must rise on the following edge.
      check({tag, "_done_edge"}, cyc, got_cyc[7] + 2);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check({tag, "_done_sticky"}, done, 1'b1);
      check({tag, "_done_nobusy"}, busy, 1'b0);
      check({tag, "_done_novalid"}, m_valid, 1'b0);
    end
    clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
    check({tag, "_cleared"}, done, 1'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom};
    for (int r = 0; r < 8; r++) mem[r * 8] = {8{8'(r)}};

    resetn = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    tick();

    run_case("full",   11'd0,    8'd8, 8'hFF, 100, 1'b0, 1'b0, 1'b1);
    run_case("sparse", 11'd0,    8'd8, 8'hA5, 100, 1'b0, 1'b1, 1'b0);
    run_case("wrap",   11'd2040, 8'd8, 8'hFF, 100, 1'b0, 1'b1, 1'b0);
    run_case("bp30a",  11'd0,    8'd8, 8'hFF, 30,  1'b0, 1'b0, 1'b0);
    run_case("bp30b",  11'd0,    8'd8, 8'hFF, 30,  1'b0, 1'b0, 1'b0);
    run_case("rand",   11'($urandom), 8'($urandom), 8'($urandom), 50, 1'b0, 1'b0, 1'b0);

    // Empty mask: no beats, done after E1.
    saw_valid   = 1'b0;
    row_mask    = 8'h00;
    m_ready     = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mask0_done", done, 1'b1);
    check("mask0_novalid", saw_valid, 1'b0);
    clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
    check("mask0_cleared", done, 1'b0);

    run_case("poke", 11'd0, 8'd8, 8'hFF, 100, 1'b1, 1'b0, 1'b0);

    // Reset after the third beat, then a fresh job.
    got_q.delete();
    base_addr   = 11'd0;
    addr_stride = 8'd8;
    row_mask    = 8'hFF;
    m_ready     = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (got_q.size() < 3 && n < 100) begin
      tick();
      n++;
    end
    check("midrst_3beats", got_q.size(), 3);
    resetn = 1'b0;
    tick();
    check_reset_outputs("midrst");
    resetn = 1'b1;
    tick();
    check("midrst_dropped", m_valid, 1'b0);
    check("midrst_idle", busy, 1'b0);
    run_case("after_rst", 11'd0, 8'd8, 8'hFF, 100, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_result_drain.md
# matmul_result_drain

Downstream stage of the 8x8 matrix-multiply wrapper. Once a multiply has completed, it reads result matrix C out of the C BRAM through the external port (port 1), one 8-element row per access. It streams the rows out on a valid/ready interface with full-throughput backpressure handling. A mask selects which rows are emitted, and a sticky done flag is held until the host clears it.

## Interface
Parameters:
- DWIDTH, 8, bits per matrix element
- MAT_MUL_SIZE, 8, elements per row and rows per matrix
- AWIDTH, 11, BRAM address width
- ADDR_STRIDE_WIDTH, 8, row stride width

Ports:
- clk  in  1  clock; clk_mem of the C BRAM is tied to this same clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- base_addr  in  AWIDTH  address of row 0 of C; sampled on start
- addr_stride  in  ADDR_STRIDE_WIDTH  address step between rows; sampled on start
- row_mask  in  MAT_MUL_SIZE  bit r=1 emits row r; sampled on start
- clear_done  in  1  clears done; acts only in DONE
- busy  out  1  high in RUN and FLUSH
- done  out  1  sticky completion flag
- bram_addr_c_ext  out  AWIDTH  read address to C BRAM port 1
- bram_rdata_c_ext  in  MAT_MUL_SIZE*DWIDTH  row data, registered, 1-cycle latency
- bram_wdata_c_ext  out  MAT_MUL_SIZE*DWIDTH  constant 0
- bram_we_c_ext  out  MAT_MUL_SIZE  constant 0
- m_valid  out  1  output beat valid
- m_ready  in  1  consumer ready
- m_data  out  MAT_MUL_SIZE*DWIDTH  row data; element 0 is in bits [DWIDTH-1:0]
- m_row_idx  out  3  row number of the current beat
- m_last  out  1  marks the final masked-in row

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - On start, latch base_addr, addr_stride and row_mask, and clear the row counter.
  - Go to RUN if row_mask≠0; otherwise go directly to DONE, emitting no beats.
- RUN:
  - Rows r=0..7 are considered in order.
  - Row address is base_addr + r*addr_stride, truncated to AWIDTH bits, so it wraps modulo 2^AWIDTH. Implement it with an accumulating address register, not a multiplier.
  - A masked-out row is skipped in a single cycle: the address advances and no read is issued.
  - A masked-in row is issued only when credit allows: fifo_count + inflight − pop < 2.
  - After row 7 is disposed of, go to FLUSH.
- FLUSH: wait for the FIFO to be empty and nothing to be in flight, then go to DONE.
- DONE: done=1. clear_done moves the block to IDLE. start is ignored.
- start is ignored in RUN, FLUSH and DONE.
- Each BRAM read returns data one cycle after issue. That data is pushed into the FIFO together with its row index and last flag.
- m_last=1 on the beat carrying the highest set bit of row_mask.
- m_data, m_row_idx and m_last stay stable while m_valid=1 and m_ready=0.
- m_valid never drops without a handshake.
- Simultaneous push and pop on a full FIFO is legal; the credit rule prevents overflow.
- bram_addr_c_ext holds its last value when no read is issued.

## Timing
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_row_idx=0, m_data=0, bram_addr_c_ext=0. FIFO is emptied and state is IDLE.
- Reset mid-operation: all state is discarded on the next edge. A read in flight is dropped.
- Start latency: start sampled at edge E0 → row-0 address driven after E0 → RAM samples it at E1 → FIFO push at E2 → m_valid=1 after E2.
- Throughput: with m_ready held at 1, one beat per cycle; 8 rows complete in 8 consecutive beats.
- done rises one edge after FIFO empty and inflight=0 are observed in FLUSH.
- busy falls on the same edge that done rises.
- With row_mask=0, done=1 after E1.

## Structure
- Package matmul_drain_pkg holds the state enum (2-bit encoding), the FIFO depth constant (2), and the width parameters.
- One sub-module, drain_fifo2:
  - 2-entry FIFO with count output.
  - Entry width MAT_MUL_SIZE*DWIDTH+4 (data, 3-bit row index, last).
  - Registered outputs.

## Test plan
- Full mask, m_ready=1: base 0, stride 8, mask 0xFF, C rows preloaded with row r = all bytes r.
  - Expect 8 consecutive beats starting 2 edges after start, m_row_idx 0..7, m_last only on row 7.
  - Expect done 1 edge after the FIFO drains, held until clear_done.
- Sparse mask 0xA5: expect 4 beats with m_row_idx 0,2,5,7; m_last on row 7; no BRAM reads for rows 1,3,4,6.
- Backpressure: random m_ready at 30% duty.
  - Expect data identical to the full-mask case, no lost or duplicated beats, and stable outputs while stalled.
  - Monitor that FIFO occupancy never exceeds 2.
- Address wrap: base 2040, stride 8, mask 0xFF. Expect row addresses 2040, 0, 8, …, 48.
- Degenerate and ignore cases:
  - Mask 0 → no m_valid and done after E1.
  - start pulsed during RUN → ignored, exactly one set of 8 beats.
  - clear_done while busy → ignored.
- Reset mid-stream: resetn=0 for 1 cycle after the 3rd beat.
  - Expect all outputs at reset values on the next edge.
  - A fresh start then streams all 8 rows correctly.
